// File: rtl/alu_pkg.sv
// Shared ALU types: data width, multiply/divide opcodes and iterative-unit FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MULLO = 2'd0,
        MULHI = 2'd1,
        DIVU  = 2'd2,
        REMU  = 2'd3
    } mul_div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_div_state_e;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the owning sequencer.
module restoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    localparam int RW = WIDTH + 1;

    // One extra bit so the shifted remainder never wraps before the compare.
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] div_ext;

    assign rem_sh  = {rem_i, bit_i};
    assign div_ext = {2'b00, div_i};

    // Quotient bit is 1 when the divisor fits; otherwise the shifted value is restored.
    always_comb begin
        q_o   = (rem_sh >= div_ext);
        rem_o = q_o ? RW'(rem_sh - div_ext) : RW'(rem_sh);
    end

endmodule

// File: rtl/seq_mul_div.sv
// Iterative 32-bit unsigned MULLO/MULHI/DIVU/REMU, one bit per cycle; divide present only with SEQ_MUL_DIV_DIV_EN.
// Latency: WIDTH+1 edges from acceptance to downstream capture; 2 edges for divide-by-zero or divide-disabled ops.
// Backpressure: start_ready low from acceptance through the DONE cycle; requests while busy are ignored, never queued.
module seq_mul_div
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             result_we,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mul_div_state_e     state_q;
    mul_div_op_e        op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     mul_acc;
    // Accepted an op that skips RUN; it completes on the following edge.
    logic               short_q;
    logic               start_ready_q;
    logic               busy_q;
    logic [WIDTH-1:0]   result_q;
    logic               result_we_q;
    logic               dbz_q;

    logic               start_short;
    logic [WIDTH-1:0]   short_res;
    logic               short_dbz;
    logic [WIDTH-1:0]   div_res;
    logic [WIDTH-1:0]   run_res;

    // Shift-add step: low half holds the unconsumed multiplier bits, high half the running sum.
    always_comb begin
        mul_acc = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        prod_d  = {mul_acc, prod_q[WIDTH-1:1]};
    end

`ifdef SEQ_MUL_DIV_DIV_EN
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   rem_d;
    logic             q_bit;

    // quo_q starts as the dividend; its MSB feeds each step and quotient bits shift in at the bottom.
    restoring_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i (rem_q),
        .bit_i (quo_q[WIDTH-1]),
        .div_i (b_q),
        .rem_o (rem_d),
        .q_o   (q_bit)
    );

    assign quo_d       = {quo_q[WIDTH-2:0], q_bit};
    assign div_res     = (op_q == REMU) ? rem_d[WIDTH-1:0] : quo_d;
    assign start_short = op[1] & (b == '0);
    assign short_res   = (op_q == REMU) ? a_q : '1;
    assign short_dbz   = 1'b1;
`else
    assign div_res     = '0;
    assign start_short = op[1];
    assign short_res   = '0;
    assign short_dbz   = 1'b0;
`endif

    // Result selected from the post-step values so it lands on the same edge RUN ends.
    always_comb begin
        run_res = (op_q == MULHI) ? prod_d[2*WIDTH-1:WIDTH] : prod_d[WIDTH-1:0];
        if (op_q[1]) begin
            run_res = div_res;
        end
    end

    // Control FSM with all outputs registered; reset discards any in-flight op silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= MULLO;
            cnt_q         <= '0;
            a_q           <= '0;
            prod_q        <= '0;
            short_q       <= 1'b0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            result_q      <= '0;
            result_we_q   <= 1'b0;
            dbz_q         <= 1'b0;
`ifdef SEQ_MUL_DIV_DIV_EN
            b_q           <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
`endif
        end else begin
            result_we_q <= 1'b0;
            dbz_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (short_q) begin
                        short_q     <= 1'b0;
                        state_q     <= DONE;
                        result_q    <= short_res;
                        result_we_q <= 1'b1;
                        dbz_q       <= short_dbz;
                    end else if (start_valid && start_ready_q) begin
                        op_q          <= mul_div_op_e'(op);
                        a_q           <= a;
                        prod_q        <= {{WIDTH{1'b0}}, b};
                        cnt_q         <= '0;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
`ifdef SEQ_MUL_DIV_DIV_EN
                        b_q           <= b;
                        quo_q         <= a;
                        rem_q         <= '0;
`endif
                        if (start_short) begin
                            short_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end else begin
                        start_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end
                end
                RUN: begin
                    prod_q <= prod_d;
`ifdef SEQ_MUL_DIV_DIV_EN
                    quo_q  <= quo_d;
                    rem_q  <= rem_d;
`endif
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        result_q    <= run_res;
                        result_we_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q       <= IDLE;
                    start_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign result      = result_q;
    assign result_we   = result_we_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed bench for seq_mul_div with a scoreboard of expected completions.
// Latency: checks acceptance-to-capture edge counts and strobe width.
// Backpressure: exercises held start_valid while the unit is busy.
module tb_seq_mul_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        result_we;
    logic        busy;
    logic        div_by_zero;

    seq_mul_div #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .result      (result),
        .result_we   (result_we),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   prev_we  = 1'b0;
    bit   cont_mode = 1'b0;
    int   last_we  = -1;
    int   accepted = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input int acc);
        exp_t        e;
        logic [63:0] p;
        p     = {32'b0, x} * {32'b0, y};
        e.acc = acc;
        e.dbz = 1'b0;
        e.lat = 33;
        e.res = 32'h0;
        case (o)
            2'd0: e.res = p[31:0];
            2'd1: e.res = p[63:32];
            default: begin
`ifdef SEQ_MUL_DIV_DIV_EN
                if (y == 32'h0) begin
                    e.lat = 2;
                    e.dbz = 1'b1;
                    e.res = (o == 2'd3) ? x : 32'hFFFF_FFFF;
                end else begin
                    e.res = (o == 2'd3) ? (x % y) : (x / y);
                end
`else
                e.lat = 2;
`endif
            end
        endcase
        return e;
    endfunction

    // Completion monitor: pops the scoreboard on every strobe.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (prev_we) chk("we_one_cycle", 32'(result_we), 32'd0);
            if (result_we === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_we", 32'(result_we), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", result, mon_e.res);
                    chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
                    chk("latency", 32'(cyc + 1 - mon_e.acc), 32'(mon_e.lat));
                    chk("ready_in_done", 32'(start_ready), 32'd0);
                    chk("busy_in_done", 32'(busy), 32'd1);
                    if (cont_mode && last_we >= 0) chk("we_spacing", 32'(cyc - last_we), 32'd34);
                    last_we = cyc;
                end
            end
            prev_we = (result_we === 1'b1);
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        @(negedge clk);
        start_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        while (start_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (start_ready !== 1'b1) begin
            chk("accept_timeout", 32'(start_ready), 32'd1);
            start_valid = 1'b0;
        end else begin
            sb.push_back(model(o, x, y, cyc + 1));
            @(posedge clk);
            #1 start_valid = 1'b0;
            @(negedge clk);
            chk("ready_after_accept", 32'(start_ready), 32'd0);
            chk("busy_after_accept", 32'(busy), 32'd1);
        end
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0;
        op = 2'd0;
        a  = 32'h0;
        b  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_start_ready", 32'(start_ready), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_result_we", 32'(result_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(start_ready), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);

        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'd2, 32'd100, 32'd7);
        do_op(2'd3, 32'd100, 32'd7);
        do_op(2'd2, 32'h8000_0000, 32'd1);
        do_op(2'd3, 32'h8000_0000, 32'd1);
        do_op(2'd2, 32'h0000_1234, 32'd0);
        do_op(2'd3, 32'h0000_1234, 32'd0);
        do_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        do_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        do_op(2'd2, 32'hDEAD_BEEF, 32'h0001_0003);
        do_op(2'd3, 32'hDEAD_BEEF, 32'h0001_0003);

        // Held request with operands changing every cycle.
        cont_mode = 1'b1;
        last_we = -1;
        accepted = 0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            start_valid = 1'b1;
            op = {1'b0, i[1]};
            a  = 32'h1000_0000 + 32'(i * 7919);
            b  = 32'(i + 3);
            if (start_ready === 1'b1) begin
                sb.push_back(model(op, a, b, cyc + 1));
                accepted++;
            end
        end
        @(negedge clk);
        start_valid = 1'b0;
        wait_drain();
        cont_mode = 1'b0;
        chk("cont_accepts", 32'(accepted), 32'd4);

        // Reset during RUN step 10 discards the op.
        @(negedge clk);
        start_valid = 1'b1;
        op = 2'd0;
        a  = 32'd7;
        b  = 32'd9;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        sb.delete();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_rst_ready", 32'(start_ready), 32'd0);
        chk("midrun_rst_result", result, 32'd0);
        chk("midrun_rst_we", 32'(result_we), 32'd0);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrun_ready_after_release", 32'(start_ready), 32'd1);
        repeat (40) @(negedge clk);
        chk("midrun_result_held", result, 32'd0);
        do_op(2'd0, 32'd3, 32'd5);
        do_op(2'd2, 32'd100, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
